// File: rtl/cp_copyblock_engine.sv
// COPYBLOCK engine: streams a block of words from the shared source memory and
// broadcasts each word to the VP memories selected by the command mask.
module cp_copyblock_engine #(
  parameter int VP_COUNT = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iCmdValid,
  output logic                oCmdReady,
  input  logic [VP_COUNT-1:0] iCmdVpMask,
  input  logic [LEN_W-1:0]    iCmdBlkLen,
  input  logic                iCmdTag,
  input  logic [ADDR_W-1:0]   iCmdDstOff,
  input  logic [ADDR_W-1:0]   iCmdSrcOff,
  output logic                oSrcReadEnable,
  output logic [ADDR_W-1:0]   oSrcAddr,
  input  logic [DATA_W-1:0]   iSrcData,
  output logic [VP_COUNT-1:0] oDstWriteEnable,
  output logic [ADDR_W-1:0]   oDstAddr,
  output logic [DATA_W-1:0]   oDstData,
  output logic                oDstTag,
  input  logic                iDstStall,
  output logic                oBusy,
  output logic                oDone,
  output logic [1:0]          oDbgState
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COPY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a command is taken on the rising edge where iCmdValid and
  // oCmdReady are both high; fields are sampled only on that edge.
  logic [1:0]          r_state;
  logic [VP_COUNT-1:0] r_mask;
  logic [LEN_W-1:0]    r_len;
  logic                r_tag;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_src;
  logic [LEN_W-1:0]    r_rcnt;
  logic [LEN_W-1:0]    r_wcnt;
  logic                r_rd_pend;
  logic                r_slot_v;
  logic [DATA_W-1:0]   r_slot;
  logic                r_skid_v;
  logic [DATA_W-1:0]   r_skid;

  logic                w_accept;
  logic                w_wr_take;
  logic [1:0]          w_occ;
  logic [1:0]          w_occ_after;
  logic                w_rd_issue;
  logic [LEN_W:0]      w_wcnt_inc;
  logic                w_last_wr;

  assign w_accept    = iCmdValid && (r_state == S_IDLE);
  assign w_wr_take   = r_slot_v && !iDstStall;
  // The in-flight read counts as occupied so its data always has a place to land.
  assign w_occ       = {1'b0, r_slot_v} + {1'b0, r_skid_v} + {1'b0, r_rd_pend};
  assign w_occ_after = w_occ - {1'b0, w_wr_take};
  assign w_rd_issue  = (r_state == S_COPY) && (r_rcnt < r_len) && !iDstStall &&
                       (w_occ_after < 2'd2);
  assign w_wcnt_inc  = {1'b0, r_wcnt} + {{LEN_W{1'b0}}, 1'b1};
  assign w_last_wr   = w_wr_take && (w_wcnt_inc == {1'b0, r_len});

  assign oCmdReady       = (r_state == S_IDLE);
  assign oBusy           = (r_state != S_IDLE);
  assign oDone           = (r_state == S_DONE);
  assign oDbgState       = r_state;
  assign oSrcReadEnable  = w_rd_issue;
  assign oSrcAddr        = w_rd_issue ? (r_src + ADDR_W'(r_rcnt)) : '0;
  assign oDstWriteEnable = r_slot_v ? r_mask : '0;
  assign oDstAddr        = r_slot_v ? (r_dst + ADDR_W'(r_wcnt)) : '0;
  assign oDstData        = r_slot_v ? r_slot : '0;
  assign oDstTag         = r_tag;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_len     <= '0;
      r_tag     <= 1'b0;
      r_dst     <= '0;
      r_src     <= '0;
      r_rcnt    <= '0;
      r_wcnt    <= '0;
      r_rd_pend <= 1'b0;
      r_slot_v  <= 1'b0;
      r_slot    <= '0;
      r_skid_v  <= 1'b0;
      r_skid    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mask    <= iCmdVpMask;
            r_len     <= iCmdBlkLen;
            r_tag     <= iCmdTag;
            r_dst     <= iCmdDstOff;
            r_src     <= iCmdSrcOff;
            r_rcnt    <= '0;
            r_wcnt    <= '0;
            r_rd_pend <= 1'b0;
            r_slot_v  <= 1'b0;
            r_skid_v  <= 1'b0;
            if ((iCmdBlkLen == '0) || (iCmdVpMask == '0)) r_state <= S_DONE;
            else                                          r_state <= S_COPY;
          end
        end
        S_COPY: begin
          r_rd_pend <= w_rd_issue;
          if (w_rd_issue) r_rcnt <= r_rcnt + 1'b1;
          if (w_wr_take)  r_wcnt <= w_wcnt_inc[LEN_W-1:0];
          if (r_rd_pend) begin
            if (r_slot_v && !w_wr_take) begin
              r_skid   <= iSrcData;
              r_skid_v <= 1'b1;
            end else if (r_skid_v) begin
              r_slot   <= r_skid;
              r_skid   <= iSrcData;
            end else begin
              r_slot   <= iSrcData;
              r_slot_v <= 1'b1;
            end
          end else if (w_wr_take) begin
            r_slot   <= r_skid;
            r_slot_v <= r_skid_v;
            r_skid_v <= 1'b0;
          end
          if (w_last_wr) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp_copyblock_engine.sv
// Bench for cp_copyblock_engine: directed and randomized COPYBLOCK commands,
// with every write compared against a word list built from the command fields.
module tb_cp_copyblock_engine;
  localparam int VP = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iCmdValid = 1'b0;
  logic          oCmdReady;
  logic [VP-1:0] iCmdVpMask = '0;
  logic [LW-1:0] iCmdBlkLen = '0;
  logic          iCmdTag = 1'b0;
  logic [AW-1:0] iCmdDstOff = '0;
  logic [AW-1:0] iCmdSrcOff = '0;
  logic          oSrcReadEnable;
  logic [AW-1:0] oSrcAddr;
  logic [DW-1:0] iSrcData = '0;
  logic [VP-1:0] oDstWriteEnable;
  logic [AW-1:0] oDstAddr;
  logic [DW-1:0] oDstData;
  logic          oDstTag;
  logic          iDstStall = 1'b0;
  logic          oBusy;
  logic          oDone;
  logic [1:0]    oDbgState;

  always #5 Clock = ~Clock;

  cp_copyblock_engine #(.VP_COUNT(VP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .Clock(Clock), .Reset(Reset), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdVpMask(iCmdVpMask), .iCmdBlkLen(iCmdBlkLen), .iCmdTag(iCmdTag),
    .iCmdDstOff(iCmdDstOff), .iCmdSrcOff(iCmdSrcOff),
    .oSrcReadEnable(oSrcReadEnable), .oSrcAddr(oSrcAddr), .iSrcData(iSrcData),
    .oDstWriteEnable(oDstWriteEnable), .oDstAddr(oDstAddr), .oDstData(oDstData),
    .oDstTag(oDstTag), .iDstStall(iDstStall), .oBusy(oBusy), .oDone(oDone),
    .oDbgState(oDbgState)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_q[$];
  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [VP-1:0] wr_mask_q[$];
  logic          wr_tag_q[$];
  int            wr_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [VP-1:0] exp_mask_q[$];
  logic          exp_tag_q[$];
  logic [63:0]   stall_vec = '0;
  logic          stall_rand = 1'b0;
  logic          prev_hold = 1'b0;
  logic [VP-1:0] prev_en = '0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source memory contents as a pure function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC35A, a * 16'h0025 + 16'h01B3};
  endfunction

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    iSrcData <= oSrcReadEnable ? mem_word(oSrcAddr) : $urandom;
  end

  // ---------------- stall driver ----------------
  always @(posedge Clock) begin
    int r;
    #1;
    r = cyc - acc;
    if (stall_rand) iDstStall = ($urandom_range(0, 2) == 0);
    else            iDstStall = (r >= 0 && r < 64) ? stall_vec[r] : 1'b0;
  end

  // ---------------- monitor ----------------
  always @(negedge Clock) begin
    if (iCmdValid && oCmdReady && !Reset) begin
      acc = cyc;
      acc_q.push_back(cyc);
    end
    if (oSrcReadEnable) begin
      rd_q.push_back(oSrcAddr);
      rd_cyc_q.push_back(cyc - acc);
    end
    if ((|oDstWriteEnable) && !iDstStall) begin
      wr_addr_q.push_back(oDstAddr);
      wr_data_q.push_back(oDstData);
      wr_mask_q.push_back(oDstWriteEnable);
      wr_tag_q.push_back(oDstTag);
      wr_cyc_q.push_back(cyc - acc);
    end
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc - acc;
    end
    if (prev_hold && !Reset) begin
      chk("hold_en", oDstWriteEnable, prev_en);
      chk("hold_addr", oDstAddr, prev_addr);
      chk("hold_data", oDstData, prev_data);
    end
    prev_hold = (|oDstWriteEnable) && iDstStall && !Reset;
    prev_en   = oDstWriteEnable;
    prev_addr = oDstAddr;
    prev_data = oDstData;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    rd_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
    wr_tag_q.delete(); wr_cyc_q.delete();
    exp_addr_q.delete(); exp_q.delete(); exp_mask_q.delete(); exp_tag_q.delete();
  endtask

  task automatic expect_cmd(input logic [VP-1:0] mask, input logic [LW-1:0] len,
                            input logic tag, input logic [AW-1:0] dst, input logic [AW-1:0] src);
    logic [AW-1:0] da, sa;
    if (mask != '0) begin
      for (int i = 0; i < int'(len); i++) begin
        da = dst + AW'(i);
        sa = src + AW'(i);
        exp_addr_q.push_back(da);
        exp_q.push_back(mem_word(sa));
        exp_mask_q.push_back(mask);
        exp_tag_q.push_back(tag);
      end
    end
  endtask

  task automatic drive_fields(input logic [VP-1:0] mask, input logic [LW-1:0] len,
                              input logic tag, input logic [AW-1:0] dst, input logic [AW-1:0] src);
    iCmdVpMask = mask; iCmdBlkLen = len; iCmdTag = tag;
    iCmdDstOff = dst;  iCmdSrcOff = src;
  endtask

  task automatic send(input logic [VP-1:0] mask, input logic [LW-1:0] len,
                      input logic tag, input logic [AW-1:0] dst, input logic [AW-1:0] src);
    bit got;
    @(posedge Clock); #1;
    drive_fields(mask, len, tag, dst, src);
    iCmdValid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clock); #1;
      if (oCmdReady) got = 1'b1;
    end
    chk("accept", 64'(got), 64'd1);
    @(posedge Clock); #1;
    iCmdValid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge Clock); #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt), 64'(target));
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(exp_addr_q[i]));
      chk({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(exp_q[i]));
      chk({tag, "_wr_mask"}, 64'(wr_mask_q[i]), 64'(exp_mask_q[i]));
      chk({tag, "_wr_tag"}, 64'(wr_tag_q[i]), 64'(exp_tag_q[i]));
    end
  endtask

  task automatic cmp_reads(input string tag, input int n, input logic [AW-1:0] src);
    logic [AW-1:0] ea;
    chk({tag, "_rd_count"}, 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < rd_q.size() && i < n; i++) begin
      ea = src + AW'(i);
      chk({tag, "_rd_addr"}, 64'(rd_q[i]), 64'(ea));
    end
  endtask

  task automatic run_cmd(input string tag, input logic [VP-1:0] mask, input logic [LW-1:0] len,
                         input logic t, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                         input bit timed);
    int n;
    int d0;
    n = (mask == '0) ? 0 : int'(len);
    d0 = done_cnt;
    clear_logs();
    expect_cmd(mask, len, t, dst, src);
    send(mask, len, t, dst, src);
    wait_done(d0 + 1, 8 * int'(len) + 60);
    @(negedge Clock); #1;
    chk({tag, "_ready_after"}, 64'(oCmdReady), 64'd1);
    chk({tag, "_busy_after"}, 64'(oBusy), 64'd0);
    cmp_writes(tag);
    cmp_reads(tag, n, src);
    if (timed) begin
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'((n == 0) ? 1 : n + 3));
      for (int i = 0; i < rd_cyc_q.size(); i++) chk({tag, "_rd_cyc"}, 64'(rd_cyc_q[i]), 64'(1 + i));
      for (int i = 0; i < wr_cyc_q.size(); i++) chk({tag, "_wr_cyc"}, 64'(wr_cyc_q[i]), 64'(3 + i));
    end else begin
      chk({tag, "_done_not_early"}, 64'(done_cyc >= n + 3), 64'd1);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 64'(oCmdReady), 64'd1);
    chk({tag, "_busy"}, 64'(oBusy), 64'd0);
    chk({tag, "_done"}, 64'(oDone), 64'd0);
    chk({tag, "_rden"}, 64'(oSrcReadEnable), 64'd0);
    chk({tag, "_srcaddr"}, 64'(oSrcAddr), 64'd0);
    chk({tag, "_wren"}, 64'(oDstWriteEnable), 64'd0);
    chk({tag, "_dstaddr"}, 64'(oDstAddr), 64'd0);
    chk({tag, "_dstdata"}, 64'(oDstData), 64'd0);
    chk({tag, "_dsttag"}, 64'(oDstTag), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, a0, nrd;
    logic [VP-1:0] m;
    logic [LW-1:0] l;
    logic [AW-1:0] s, d;

    repeat (3) @(posedge Clock);
    @(negedge Clock); #1;
    chk_quiet("reset_idle");
    @(posedge Clock); #1;
    Reset = 1'b0;

    run_cmd("basic", 4'b0101, 8'd4, 1'b1, 16'h0200, 16'h0010, 1'b1);

    // Stall during cycles 4-5 after accept.
    stall_vec = 64'h30;
    run_cmd("stall", 4'b0101, 8'd4, 1'b1, 16'h0200, 16'h0010, 1'b0);
    chk("stall_done_cyc", 64'(done_cyc), 64'd9);
    chk("stall_wr_cyc0", 64'(wr_cyc_q[0]), 64'd3);
    chk("stall_wr_cyc1", 64'(wr_cyc_q[1]), 64'd6);
    chk("stall_wr_cyc2", 64'(wr_cyc_q[2]), 64'd7);
    chk("stall_wr_cyc3", 64'(wr_cyc_q[3]), 64'd8);
    chk("stall_rd_cyc3", 64'(rd_cyc_q[3]), 64'd6);
    stall_vec = '0;

    run_cmd("len0", 4'b0101, 8'd0, 1'b0, 16'h0200, 16'h0010, 1'b1);
    run_cmd("mask0", 4'b0000, 8'd5, 1'b0, 16'h0200, 16'h0010, 1'b1);
    run_cmd("wrap", 4'b1111, 8'd3, 1'b0, 16'hFFFF, 16'hFFFE, 1'b1);

    // Reset in the middle of an 8-word copy, right after the third write.
    clear_logs();
    d0 = done_cnt;
    send(4'b0011, 8'd8, 1'b1, 16'h0100, 16'h0040);
    for (int i = 0; i < 40 && wr_addr_q.size() < 3; i++) begin
      @(negedge Clock); #1;
    end
    Reset = 1'b1;
    #1;
    chk_quiet("reset_mid");
    nrd = rd_q.size();
    chk("reset_mid_reads", 64'(nrd), 64'd5);
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (15) @(negedge Clock);
    #1;
    chk("reset_mid_no_done", 64'(done_cnt), 64'(d0));
    chk("reset_mid_writes", 64'(wr_addr_q.size()), 64'd3);
    chk("reset_mid_no_reads", 64'(rd_q.size()), 64'(nrd));
    chk("reset_mid_third_addr", 64'(wr_addr_q[2]), 64'h0102);
    chk("reset_mid_ready", 64'(oCmdReady), 64'd1);

    // iCmdValid held through a 2-word copy while the fields keep changing.
    clear_logs();
    d0 = done_cnt;
    a0 = acc_q.size();
    expect_cmd(4'b0011, 8'd2, 1'b0, 16'h0300, 16'h0020);
    expect_cmd(4'b1100, 8'd3, 1'b1, 16'h0400, 16'h0050);
    @(posedge Clock); #1;
    drive_fields(4'b0011, 8'd2, 1'b0, 16'h0300, 16'h0020);
    iCmdValid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clock); #1;
      if (i < 4) drive_fields(VP'($urandom), LW'($urandom_range(1, 20)), 1'($urandom),
                              AW'($urandom), AW'($urandom));
      else       drive_fields(4'b1100, 8'd3, 1'b1, 16'h0400, 16'h0050);
    end
    for (int i = 0; i < 40 && acc_q.size() < a0 + 2; i++) begin
      @(negedge Clock); #1;
    end
    @(posedge Clock); #1;
    iCmdValid = 1'b0;
    wait_done(d0 + 2, 60);
    @(negedge Clock); #1;
    chk("b2b_accepts", 64'(acc_q.size() - a0), 64'd2);
    if (acc_q.size() >= a0 + 2)
      chk("b2b_gap", 64'(acc_q[a0 + 1] - acc_q[a0]), 64'd6);
    cmp_writes("b2b");

    // Randomized commands; later ones with random stalls.
    for (int t = 0; t < 10; t++) begin
      m = VP'($urandom_range(1, 15));
      l = LW'($urandom_range(1, 12));
      d = AW'($urandom);
      s = (t % 3 == 0) ? AW'(16'hFFF8 + AW'($urandom_range(0, 7))) : AW'($urandom);
      stall_rand = (t >= 4);
      run_cmd(stall_rand ? "rand_stall" : "rand", m, l, 1'($urandom), d, s, !stall_rand);
    end
    stall_rand = 1'b0;

    repeat (2) @(posedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp_copyblock_engine.md
# cp_copyblock_engine

Executes COPYBLOCK commands issued by the control processor. Accepts one command (VP mask, block length, tag, destination offset, source offset), streams BLKLEN words out of the shared source memory, and broadcasts each word to the selected VP memories. One command in flight at a time; completion is signalled with a one-cycle done pulse the control processor uses to sequence its next COPYBLOCK or DELIVER_COMMAND.

## Interface
- VP_COUNT, 4, number of VP destination ports (mask width)
- ADDR_W, 16, source and destination address width
- DATA_W, 32, word width
- LEN_W, 8, block length field width

- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high
- iCmdValid  in  1  command present
- oCmdReady  out  1  engine idle, command accepted on iCmdValid&oCmdReady
- iCmdVpMask  in  VP_COUNT  destination VP select, bit n = VP n
- iCmdBlkLen  in  LEN_W  words to copy
- iCmdTag  in  1  destination space: 0 data memory, 1 instruction memory
- iCmdDstOff  in  ADDR_W  first destination address
- iCmdSrcOff  in  ADDR_W  first source address
- oSrcReadEnable  out  1  source read strobe
- oSrcAddr  out  ADDR_W  source read address
- iSrcData  in  DATA_W  read data, valid the cycle after oSrcReadEnable
- oDstWriteEnable  out  VP_COUNT  per-VP write strobe
- oDstAddr  out  ADDR_W  destination address
- oDstData  out  DATA_W  destination data
- oDstTag  out  1  latched iCmdTag
- iDstStall  in  1  destination busy; write not taken this cycle
- oBusy  out  1  command in progress
- oDone  out  1  one-cycle completion pulse

## Operation
- States: IDLE, COPY, DONE.
- IDLE: oCmdReady=1. On accept latch all fields. BlkLen=0 or VpMask=0 -> DONE directly, no reads or writes. Else -> COPY.
- COPY: read counter R (words requested), write counter W (words written), both start 0.
  - Issue read when R<BlkLen, iDstStall=0, and buffer has a free entry after this cycle's write; oSrcAddr=SrcOff+R, R++.
  - Returning data goes to write slot, or to single skid entry if slot is held by a stalled write. Buffer depth 2; never overflows.
  - Write slot valid -> oDstWriteEnable=latched mask, oDstAddr=DstOff+W, oDstData=slot. Taken when iDstStall=0: W++, skid moves into slot.
  - While stalled, oDstWriteEnable/oDstAddr/oDstData held stable.
  - W==BlkLen -> DONE.
- DONE: oDone=1 for one cycle, -> IDLE.
- Address arithmetic modulo 2^ADDR_W (wrap from all-ones to 0 silently).
- iCmdValid while not IDLE ignored; fields sampled only at accept.
- oBusy = state != IDLE.

## Timing
- Reset (any time, including mid-copy): state IDLE, counters and buffer cleared; oCmdReady=1, all other outputs 0; no oDone for the aborted command.
- Accept at edge 0. First read cycle 1, first write cycle 3 (two-cycle latency: read + register).
- Unstalled, N words: reads cycles 1..N, writes cycles 3..N+2, oDone cycle N+3, oCmdReady=1 cycle N+4; next accept edge possible end of cycle N+4.
- Each stall cycle delays remaining writes and oDone by exactly one cycle; no word dropped or duplicated.
- BlkLen=0 or mask=0: oDone cycle 1, no strobes.
- Stall asserted the cycle a read returns: data captured in skid; no read issued while stalled.

## Test plan
- Reset during idle and at word 3 of 8-word copy -> all outputs 0, oCmdReady=1, no oDone, no further strobes.
- Mask=4'b0101, BlkLen=4, Src=0x0010, Dst=0x0200, Tag=1, no stall -> reads 0x10..0x13 cycles 1-4, writes 0x200..0x203 with enable 0101 cycles 3-6, oDstTag=1, oDone cycle 7.
- Same copy with iDstStall high cycles 4-5 -> writes 0x200 cycle 3, 0x201 held cycles 4-6, remaining at 7-8, oDone cycle 9, data order/values exact.
- BlkLen=0, then Mask=0 with BlkLen=5 -> oDone cycle 1 each, zero reads and writes.
- Src=0xFFFE, Dst=0xFFFF, BlkLen=3 -> source addresses FFFE,FFFF,0000; destination FFFF,0000,0001.
- iCmdValid held high through a 2-word copy with changing fields -> second command accepted only after oDone, using fields at that accept edge.
